// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - types shared by the signal generator and the signal meter
package sig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  typedef enum logic [1:0] {
    SIG_SQUARE   = 2'd0,
    SIG_TRIANGLE = 2'd1,
    SIG_SAW      = 2'd2,
    SIG_SINE     = 2'd3
  } signal_t;

endpackage

// File: rtl/sig_meter_if.sv
// rtl/sig_meter_if.sv - measurement result port (valid/ready plus status flags)
interface sig_meter_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
);

  logic              meas_valid;
  logic              meas_ready;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic [DATA_W-1:0] sample_min;
  logic [DATA_W-1:0] sample_max;
  logic              overrun;
  logic              no_signal;

  modport master (
    output meas_valid, period, high_time, sample_min, sample_max, overrun, no_signal,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, period, high_time, sample_min, sample_max, overrun, no_signal,
    output meas_ready
  );

endinterface

// File: rtl/sig_meter_xdet.sv
// rtl/sig_meter_xdet.sv - hysteresis comparator with level register, emits rise/fall pulses
module sig_meter_xdet #(
  parameter int DATA_W = 8,
  parameter int HYST   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  output logic              rise,
  output logic              fall
);

  localparam logic [DATA_W:0] HYST_EXT = (DATA_W+1)'(HYST);

  logic [DATA_W:0]   hi_sum;
  logic [DATA_W:0]   lo_diff;
  logic [DATA_W-1:0] hi_lim;
  logic [DATA_W-1:0] lo_lim;
  logic              level;

  // Guard bit catches carry/borrow so the band saturates at the sample range ends.
  always_comb begin
    hi_sum  = {1'b0, threshold} + HYST_EXT;
    lo_diff = {1'b0, threshold} - HYST_EXT;
    hi_lim  = hi_sum[DATA_W]  ? '1 : hi_sum[DATA_W-1:0];
    lo_lim  = lo_diff[DATA_W] ? '0 : lo_diff[DATA_W-1:0];
  end

  assign rise = !clear && !level && (sample >= hi_lim);
  assign fall = !clear &&  level && (sample <= lo_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
    end else if (clear) begin
      level <= 1'b0;
    end else if (rise) begin
      level <= 1'b1;
    end else if (fall) begin
      level <= 1'b0;
    end
  end

endmodule

// File: rtl/sig_meter.sv
// rtl/sig_meter.sv - recovers period, high time and min/max of a sampled waveform
module sig_meter
  import sig_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  sig_meter_if.master       meas
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  meter_state_t      state;
  meter_state_t      state_d;
  logic              rise;
  logic              fall;
  logic              timeout;
  logic              publish;
  logic              accept;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  ht;
  logic              hi_seen;
  logic [DATA_W-1:0] cur_min;
  logic [DATA_W-1:0] cur_max;
  logic [DATA_W-1:0] pub_min;
  logic [DATA_W-1:0] pub_max;
  logic [TO_W-1:0]   tcnt;

  sig_meter_xdet #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_xdet (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == IDLE),
    .sample    (sample),
    .threshold (threshold),
    .rise      (rise),
    .fall      (fall)
  );

  assign accept  = meas.meas_valid & meas.meas_ready;
  assign pub_min = (sample < cur_min) ? sample : cur_min;
  assign pub_max = (sample > cur_max) ? sample : cur_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    timeout = 1'b0;
    publish = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM, MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
          publish = (state == MEASURE);
        end else if (tcnt == TO_LAST) begin
          timeout = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ht stays 0 until the first falling crossing, so it can be published as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ht      <= '0;
      hi_seen <= 1'b0;
      cur_min <= '0;
      cur_max <= '0;
      tcnt    <= '0;
    end else if (state == IDLE || !enable) begin
      cnt     <= '0;
      ht      <= '0;
      hi_seen <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (rise || timeout) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (rise) begin
        cnt     <= CNT_W'(1);
        ht      <= '0;
        hi_seen <= 1'b0;
        cur_min <= sample;
        cur_max <= sample;
      end else if (state == MEASURE) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        cur_min <= pub_min;
        cur_max <= pub_max;
        if (fall && !hi_seen) begin
          ht      <= cnt;
          hi_seen <= 1'b1;
        end
      end
    end
  end

  // A result that finds the previous one still unread is dropped, never merged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas.meas_valid <= 1'b0;
      meas.period     <= '0;
      meas.high_time  <= '0;
      meas.sample_min <= '0;
      meas.sample_max <= '0;
      meas.overrun    <= 1'b0;
      meas.no_signal  <= 1'b0;
    end else begin
      if (publish) begin
        if (meas.meas_valid && !meas.meas_ready) begin
          meas.overrun <= 1'b1;
        end else begin
          meas.meas_valid <= 1'b1;
          meas.period     <= cnt;
          meas.high_time  <= ht;
          meas.sample_min <= pub_min;
          meas.sample_max <= pub_max;
        end
      end else if (accept) begin
        meas.meas_valid <= 1'b0;
      end
      if (accept) meas.overrun <= 1'b0;
      if (rise && enable) begin
        meas.no_signal <= 1'b0;
      end else if (timeout) begin
        meas.no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sig_meter.sv
// tb/tb_sig_meter.sv - self-checking bench for sig_meter
module tb_sig_meter;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int HY = 8;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] sample = '0;
  logic [DW-1:0] threshold = 8'd128;

  sig_meter_if #(.DATA_W(DW), .CNT_W(CW)) mif ();

  sig_meter #(
    .DATA_W  (DW),
    .CNT_W   (CW),
    .HYST    (HY),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sample    (sample),
    .threshold (threshold),
    .meas      (mif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: timestamps of crossings rather than running counters
  int     m_phase;
  bit     m_level;
  longint t, t_rise, t_fall;
  int     mn, mx, since;
  bit     e_valid, e_ovr, e_nosig;
  longint e_per, e_ht;
  int     e_min, e_max;

  task automatic model_reset();
    m_phase = 0; m_level = 0; t_rise = 0; t_fall = -1; mn = 0; mx = 0; since = 0;
    e_valid = 0; e_ovr = 0; e_nosig = 0; e_per = 0; e_ht = 0; e_min = 0; e_max = 0;
  endtask

  task automatic model_step(input bit en, input int s, input int thr, input bit rdy);
    int hi, lo, p_mn, p_mx;
    bit rise, fall, acc, pub;
    longint p_per, p_ht;
    hi = (thr + HY > 255) ? 255 : thr + HY;
    lo = (thr - HY < 0) ? 0 : thr - HY;
    rise = (m_phase != 0) && !m_level && (s >= hi);
    fall = (m_phase != 0) && m_level && (s <= lo);
    acc = e_valid && rdy;
    pub = 0; p_per = 0; p_ht = 0; p_mn = 0; p_mx = 0;
    if (m_phase == 0) begin
      m_level = 0; since = 0;
      if (en) m_phase = 1;
    end else if (!en) begin
      m_phase = 0;
    end else begin
      if (rise) m_level = 1; else if (fall) m_level = 0;
      if (rise) begin
        e_nosig = 0; since = 0;
        if (m_phase == 2) begin
          pub = 1;
          p_per = t - t_rise;
          p_ht = (t_fall >= 0) ? t_fall - t_rise : 0;
          p_mn = (s < mn) ? s : mn;
          p_mx = (s > mx) ? s : mx;
        end
        m_phase = 2; t_rise = t; t_fall = -1; mn = s; mx = s;
      end else begin
        if (m_phase == 2) begin
          if (fall && t_fall < 0) t_fall = t;
          if (s < mn) mn = s;
          if (s > mx) mx = s;
        end
        since++;
        if (since == TO) begin
          e_nosig = 1; m_phase = 1; since = 0;
        end
      end
    end
    if (pub) begin
      if (e_valid && !rdy) e_ovr = 1;
      else begin
        e_valid = 1; e_per = p_per; e_ht = p_ht; e_min = p_mn; e_max = p_mx;
      end
    end else if (acc) begin
      e_valid = 0;
    end
    if (acc) e_ovr = 0;
    t++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    checks++;
    if (mif.meas_valid !== e_valid || mif.period !== 32'(e_per) || mif.high_time !== 32'(e_ht) ||
        mif.sample_min !== 8'(e_min) || mif.sample_max !== 8'(e_max) ||
        mif.overrun !== e_ovr || mif.no_signal !== e_nosig) begin
      failures++;
      $display("FAIL model t=%0d: got v=%0d p=%0d h=%0d mn=%0d mx=%0d ov=%0d ns=%0d expected v=%0d p=%0d h=%0d mn=%0d mx=%0d ov=%0d ns=%0d",
               t, mif.meas_valid, mif.period, mif.high_time, mif.sample_min, mif.sample_max,
               mif.overrun, mif.no_signal, e_valid, e_per, e_ht, e_min, e_max, e_ovr, e_nosig);
    end
  endtask

  task automatic cycle(input bit en, input int s, input int thr, input bit rdy);
    enable = en;
    sample = 8'(s);
    threshold = 8'(thr);
    mif.meas_ready = rdy;
    model_step(en, s, thr, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, mif.meas_valid, 0);
    check({tag, "_period"}, mif.period, 0);
    check({tag, "_high"}, mif.high_time, 0);
    check({tag, "_min"}, mif.sample_min, 0);
    check({tag, "_max"}, mif.sample_max, 0);
    check({tag, "_ovr"}, mif.overrun, 0);
    check({tag, "_nosig"}, mif.no_signal, 0);
  endtask

  typedef struct {
    int hi, lo, hlen, llen, thr;
    int per, ht, mn, mx;
  } scen_t;

  scen_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, cur, hold, s, thr;
    bit en, rdy;

    tbl[0] = '{255, 0,   5, 5, 128, 10, 5, 0,   255};
    tbl[1] = '{255, 128, 3, 7, 192, 10, 3, 128, 255};
    tbl[2] = '{255, 0,   4, 6, 250, 10, 4, 0,   255};
    tbl[3] = '{255, 0,   2, 5, 3,   7,  2, 0,   255};
    tbl[4] = '{200, 20,  6, 3, 100, 9,  6, 20,  200};

    mif.meas_ready = 1'b0;
    t = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(0, 0, tbl[i].thr, 1);
      cycle(0, 0, tbl[i].thr, 1);
      for (int p = 0; p < 4; p++) begin
        for (int k = 0; k < tbl[i].llen; k++) cycle(1, tbl[i].lo, tbl[i].thr, 1);
        for (int k = 0; k < tbl[i].hlen; k++) cycle(1, tbl[i].hi, tbl[i].thr, 1);
      end
      check($sformatf("scen%0d_period", i), mif.period, tbl[i].per);
      check($sformatf("scen%0d_high", i), mif.high_time, tbl[i].ht);
      check($sformatf("scen%0d_min", i), mif.sample_min, tbl[i].mn);
      check($sformatf("scen%0d_max", i), mif.sample_max, tbl[i].mx);
    end

    // Chatter inside the hysteresis band never crosses: timeout after TO armed cycles
    cycle(0, 0, 128, 1);
    cycle(0, 0, 128, 1);
    first = -1;
    for (int c = 0; c < 200 && first < 0; c++) begin
      cycle(1, (c % 2) ? 130 : 126, 128, 1);
      if (mif.no_signal) first = c;
    end
    check("timeout_cycle", first, TO);
    check("timeout_no_result", mif.meas_valid, 0);
    first = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(1, (c % 10 < 5) ? 0 : 255, 128, 1);
      if (c == 5) check("nosig_clear", mif.no_signal, 0);
      if (mif.meas_valid && first < 0) first = c;
    end
    check("rearm_first_result", first, 15);

    // Consumer stalls: first result held, later ones dropped
    cycle(0, 0, 128, 1);
    cycle(0, 0, 128, 1);
    for (int c = 0; c < 40; c++) begin
      cycle(1, (c % 10 < 5) ? 0 : 255, 128, 0);
      if (c == 20) check("stall_valid_early", mif.meas_valid, 1);
    end
    check("stall_valid", mif.meas_valid, 1);
    check("stall_period", mif.period, 10);
    check("stall_high", mif.high_time, 5);
    check("stall_overrun", mif.overrun, 1);
    cycle(1, 0, 128, 1);
    check("release_valid", mif.meas_valid, 0);
    check("release_overrun", mif.overrun, 0);

    // Asynchronous reset in the middle of a measurement
    cycle(0, 0, 128, 1);
    cycle(0, 0, 128, 1);
    for (int c = 0; c < 30; c++) cycle(1, (c % 10 < 5) ? 0 : 255, 128, 0);
    check("pre_reset_valid", mif.meas_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    first = -1;
    for (int c = 0; c < 25; c++) begin
      cycle(1, (c % 10 < 5) ? 0 : 255, 128, 1);
      if (mif.meas_valid && first < 0) first = c;
    end
    check("post_reset_first_result", first, 15);

    // Randomized traffic against the model
    cur = 0; hold = 0; thr = 128;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) thr = $urandom_range(0, 255);
      en = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (hold == 0) begin
        hold = (c / 500 % 3 == 2) ? $urandom_range(1, 80) : $urandom_range(1, 30);
        cur = (cur < 128) ? $urandom_range(160, 255) : $urandom_range(0, 90);
      end
      hold--;
      s = (c / 500 % 3 == 0) ? $urandom_range(0, 255) : cur;
      cycle(en, s, thr, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
